// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store,
// with fetch anti-starvation and a memory-response timeout.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        if_ack,
  output logic        d_ack,
  output logic        err
);

  localparam int unsigned SW = (MAX_DATA_STREAK >= 1) ? $clog2(MAX_DATA_STREAK + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES >= 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY_IF = 2'd1,
    ST_BUSY_D  = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_mem_sel;
  logic [SW-1:0]   r_streak;
  logic [TW-1:0]   r_timer;

  logic w_busy;
  logic w_done;
  logic w_tmo;
  logic w_arb;
  logic w_f_ok;
  logic w_d_ok;
  logic w_starve;
  logic w_grant_d;
  logic w_grant_f;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_done   = w_busy & mem_ready;
  assign w_tmo    = (TIMEOUT_CYCLES != 0) && w_busy && !mem_ready &&
                    (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Re-arbitrate when idle or on completion, excluding the requester just served.
  assign w_arb     = (r_state == ST_IDLE) | w_done;
  assign w_f_ok    = if_req & (r_state != ST_BUSY_IF);
  assign w_d_ok    = d_req & (r_state != ST_BUSY_D);
  assign w_starve  = (r_streak == SW'(MAX_DATA_STREAK));
  assign w_grant_d = w_arb & w_d_ok & ~(w_f_ok & w_starve);
  assign w_grant_f = w_arb & w_f_ok & ~w_grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_mem_sel <= 1'b0;
      r_streak  <= '0;
      r_timer   <= '0;
    end else if (w_grant_d) begin
      r_state   <= ST_BUSY_D;
      r_mem_sel <= 1'b1;
      r_timer   <= '0;
      if (!if_req)
        r_streak <= '0;
      else if (!w_starve)
        r_streak <= r_streak + SW'(1);
    end else if (w_grant_f) begin
      r_state   <= ST_BUSY_IF;
      r_mem_sel <= 1'b0;
      r_timer   <= '0;
      r_streak  <= '0;
    end else if (w_done || w_tmo) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else if (w_busy) begin
      r_timer <= r_timer + TW'(1);
    end
  end

  assign mem_req   = w_busy;
  assign mem_we    = (r_state == ST_BUSY_D) & d_we;
  assign mem_sel   = r_mem_sel;
  assign mem_addr  = r_mem_sel ? d_addr : if_addr;
  assign mem_wdata = r_mem_sel ? d_wdata : 32'd0;
  assign if_ack    = (r_state == ST_BUSY_IF) & mem_ready;
  assign d_ack     = (r_state == ST_BUSY_D) & mem_ready;
  assign err       = w_tmo;

endmodule
